// File: rtl/control_loop_cmd_master.sv
// control_loop_cmd_master
//
// Host-side initiator for the control-loop command interface. Read and write
// requests from the CPU register bridge are queued in a small FIFO and issued
// one at a time over the four-phase start_cmd/finish_cmd handshake. The
// control loop's word_out is captured and returned to the host together with
// a status code. Both handshake phases are guarded by a cycle timer so that a
// silent or stuck responder can never hang the host.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      host request handshake (req_ready = FIFO not full)
//   req_cmd, req_data        command code (write bit included) and write data
//   resp_valid/resp_ready    host response handshake, held until accepted
//   resp_data, resp_status   captured word_out; 00 ok, 01 no finish, 10 finish stuck
//   busy                     FIFO non-empty or a command in progress
//   cmd, word_in, start_cmd  command, data and strobe towards the control loop
//   word_out, finish_cmd     result and completion strobe from the control loop

module control_loop_cmd_master #(
    parameter int CMD_WID        = 8,
    parameter int DATA_WID       = 48,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_WID    = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CMD_WID-1:0]  req_cmd,
    input  logic [DATA_WID-1:0] req_data,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_WID-1:0] resp_data,
    output logic [1:0]          resp_status,
    output logic                busy,
    output logic [CMD_WID-1:0]  cmd,
    output logic [DATA_WID-1:0] word_in,
    output logic                start_cmd,
    input  logic [DATA_WID-1:0] word_out,
    input  logic                finish_cmd
);

    localparam int PTR_WID = $clog2(FIFO_DEPTH);
    localparam int PTR_W1  = PTR_WID + 1;
    localparam logic [TIMEOUT_WID-1:0] TIMER_LAST = TIMEOUT_WID'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_NO_FIN = 2'b01;
    localparam logic [1:0] ST_STUCK  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIN,
        WAIT_REL,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [CMD_WID-1:0]  fifo_cmd  [FIFO_DEPTH];
    logic [DATA_WID-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_WID:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic                fifo_empty, full_nxt, push, pop;
    logic [CMD_WID-1:0]  head_cmd;
    logic [DATA_WID-1:0] head_data;

    logic [TIMEOUT_WID-1:0] timer, timer_nxt;
    logic [CMD_WID-1:0]     cmd_nxt;
    logic [DATA_WID-1:0]    word_in_nxt, resp_data_nxt;
    logic [1:0]             resp_status_nxt;
    logic                   start_nxt, resp_valid_nxt;

    // The extra pointer bit tells a full FIFO apart from an empty one. req_ready
    // is a registered copy of "not full", so a pop in the same cycle as a
    // blocked push only opens the slot for the following cycle.
    assign push       = req_valid && req_ready;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign wr_ptr_nxt = wr_ptr + PTR_W1'(push);
    assign rd_ptr_nxt = rd_ptr + PTR_W1'(pop);
    assign full_nxt   = (wr_ptr_nxt[PTR_WID] != rd_ptr_nxt[PTR_WID]) &&
                        (wr_ptr_nxt[PTR_WID-1:0] == rd_ptr_nxt[PTR_WID-1:0]);
    assign head_cmd   = fifo_cmd[rd_ptr[PTR_WID-1:0]];
    assign head_data  = fifo_data[rd_ptr[PTR_WID-1:0]];

    // FIFO storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd[wr_ptr[PTR_WID-1:0]]  <= req_cmd;
            fifo_data[wr_ptr[PTR_WID-1:0]] <= req_data;
        end
    end

    // Pointers plus the registered host-side flags. Reset holds req_ready low
    // so the host cannot push until the first edge after release, and busy is
    // computed from next-state values so it stays a plain flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            req_ready <= !full_nxt;
            busy      <= (wr_ptr_nxt != rd_ptr_nxt) || (state_nxt != IDLE);
        end
    end

    // Handshake state machine. WAIT_FIN waits for the responder to finish (or
    // gives up after TIMEOUT_CYCLES with status 01 and zero data); WAIT_REL
    // waits for finish_cmd to drop again so the next start_cmd never overlaps
    // a still-high finish, falling back to status 10 if it never drops. A
    // no-finish status is kept in that case since it describes the first
    // failure. RESP raises resp_valid one cycle after entry and holds it until
    // the host takes it. cmd and word_in only change when leaving IDLE.
    always_comb begin
        state_nxt       = state;
        cmd_nxt         = cmd;
        word_in_nxt     = word_in;
        start_nxt       = start_cmd;
        timer_nxt       = timer;
        resp_data_nxt   = resp_data;
        resp_status_nxt = resp_status;
        resp_valid_nxt  = resp_valid;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    cmd_nxt     = head_cmd;
                    word_in_nxt = head_data;
                    start_nxt   = 1'b1;
                    timer_nxt   = '0;
                    state_nxt   = WAIT_FIN;
                end
            end
            WAIT_FIN: begin
                if (finish_cmd) begin
                    resp_data_nxt   = word_out;
                    resp_status_nxt = ST_OK;
                    start_nxt       = 1'b0;
                    timer_nxt       = '0;
                    state_nxt       = WAIT_REL;
                end else if (timer == TIMER_LAST) begin
                    resp_data_nxt   = '0;
                    resp_status_nxt = ST_NO_FIN;
                    start_nxt       = 1'b0;
                    timer_nxt       = '0;
                    state_nxt       = WAIT_REL;
                end else begin
                    timer_nxt = timer + TIMEOUT_WID'(1);
                end
            end
            WAIT_REL: begin
                if (!finish_cmd) begin
                    state_nxt = RESP;
                end else if (timer == TIMER_LAST) begin
                    if (resp_status != ST_NO_FIN) begin
                        resp_status_nxt = ST_STUCK;
                    end
                    state_nxt = RESP;
                end else begin
                    timer_nxt = timer + TIMEOUT_WID'(1);
                end
            end
            RESP: begin
                if (!resp_valid) begin
                    resp_valid_nxt = 1'b1;
                end else if (resp_ready) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears everything at once, including
    // start_cmd in the middle of a handshake, so an in-flight command is
    // simply dropped without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd         <= '0;
            word_in     <= '0;
            start_cmd   <= 1'b0;
            timer       <= '0;
            resp_data   <= '0;
            resp_status <= ST_OK;
            resp_valid  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd         <= cmd_nxt;
            word_in     <= word_in_nxt;
            start_cmd   <= start_nxt;
            timer       <= timer_nxt;
            resp_data   <= resp_data_nxt;
            resp_status <= resp_status_nxt;
            resp_valid  <= resp_valid_nxt;
        end
    end

endmodule
